// File: rtl/cpu_sequencer.sv
// Control sequencer upstream of the instruction decoder: owns the PC, the
// instruction register and the one-hot fetch/exec1/exec2 cycle state, and
// halts on STP until resume is pulsed.
module cpu_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              pc_load,
    input  logic              pc_inc,
    input  logic              resume,
    output logic [2:0]        state,
    output logic [3:0]        inst,
    output logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_req,
    output logic              halted
);

    typedef enum logic [2:0] {
        StHalt  = 3'b000,
        StFetch = 3'b001,
        StExec1 = 3'b010,
        StExec2 = 3'b100
    } state_e;

    localparam logic [3:0] OpStp = 4'b0111;
    localparam logic [3:0] OpLda = 4'b1000;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0011;
    localparam logic [3:0] OpXch = 4'b1101;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [3:0]        opcode;
    logic              two_exec;

    assign opcode   = ir_q[DATA_W-1 -: 4];
    assign two_exec = (opcode == OpLda) || (opcode == OpAdd) ||
                      (opcode == OpSub) || (opcode == OpXch);

    // Next-state, PC and IR update logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = StExec1;
                end
            end
            StExec1: begin
                // Load wins over increment when the decoder asserts both.
                if (pc_load) begin
                    pc_d = ir_q[ADDR_W-1:0];
                end else if (pc_inc) begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                if (opcode == OpStp) begin
                    state_d = StHalt;
                end else if (two_exec) begin
                    state_d = StExec2;
                end else begin
                    state_d = StFetch;
                end
            end
            StExec2: begin
                state_d = StFetch;
            end
            StHalt: begin
                if (resume) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StFetch;
                end
            end
            // Corrupted encodings fall back to FETCH with PC and IR untouched.
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // State, PC and IR registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs decoded only from registered state.
    always_comb begin
        state     = state_q;
        inst      = ir_q[DATA_W-1 -: 4];
        operand   = ir_q[ADDR_W-1:0];
        pc        = pc_q;
        fetch_req = (state_q == StFetch);
        halted    = (state_q == StHalt);
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model schedules
// stimulus and pushes the expected per-cycle outputs; a monitor on the
// falling edge pops and compares.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        pc_load;
    logic        pc_inc;
    logic        resume;
    logic [2:0]  state;
    logic [3:0]  inst;
    logic [11:0] operand;
    logic [11:0] pc;
    logic        fetch_req;
    logic        halted;

    cpu_sequencer #(
        .ADDR_W(12),
        .DATA_W(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .resume    (resume),
        .state     (state),
        .inst      (inst),
        .operand   (operand),
        .pc        (pc),
        .fetch_req (fetch_req),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] pc;
        logic [3:0]  inst;
        logic [11:0] opnd;
        logic        freq;
        logic        halt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    tests  = 0;
    int    failed = 0;
    int    cyc    = 0;

    // Architectural model state.
    logic [11:0] m_pc;
    logic [15:0] m_ir;

    function automatic obs_t mk(input logic [2:0] st, input logic [11:0] p,
                                input logic [15:0] ir);
        obs_t o;
        o.st   = st;
        o.pc   = p;
        o.inst = ir[15:12];
        o.opnd = ir[11:0];
        o.freq = (st == 3'b001);
        o.halt = (st == 3'b000);
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic bit is_two_exec(input logic [3:0] op);
        return op == 4'b1000 || op == 4'b0010 || op == 4'b0011 || op == 4'b1101;
    endfunction

    // Monitor: compare every cycle that has an expectation queued.
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string n;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a.st   = state;
            a.pc   = pc;
            a.inst = inst;
            a.opnd = operand;
            a.freq = fetch_req;
            a.halt = halted;
            tests = tests + 1;
            if (a !== e) begin
                failed = failed + 1;
                $display("FAIL %s cyc=%0d got st=%b pc=%h inst=%h opnd=%h freq=%b halt=%b want st=%b pc=%h inst=%h opnd=%h freq=%b halt=%b",
                         n, cyc, a.st, a.pc, a.inst, a.opnd, a.freq, a.halt,
                         e.st, e.pc, e.inst, e.opnd, e.freq, e.halt);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic step(input string nm, input logic [2:0] st, input logic rst,
                        input logic mr, input logic [15:0] rd, input logic ld,
                        input logic inc, input logic rs);
        reset     = rst;
        mem_ready = mr;
        mem_rdata = rd;
        pc_load   = ld;
        pc_inc    = inc;
        resume    = rs;
        exp_q.push_back(mk(st, m_pc, m_ir));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Execute one instruction at the ISA level.
    task automatic run_instr(input string nm, input logic [15:0] w, input int stalls,
                             input logic ld, input logic inc, input int hcyc,
                             input bit rst2);
        logic [3:0] op;
        op = w[15:12];
        for (int i = 0; i < stalls; i++) begin
            step({nm, "_stall"}, 3'b001, 1'b0, 1'b0, 16'($urandom), rb(), rb(), rb());
        end
        step({nm, "_fetch"}, 3'b001, 1'b0, 1'b1, w, rb(), rb(), rb());
        m_ir = w;
        step({nm, "_exec1"}, 3'b010, 1'b0, rb(), 16'($urandom), ld, inc, rb());
        if (ld) begin
            m_pc = w[11:0];
        end else if (inc) begin
            m_pc = m_pc + 12'd1;
        end
        if (op == 4'b0111) begin
            for (int i = 0; i < hcyc; i++) begin
                step({nm, "_halt"}, 3'b000, 1'b0, rb(), 16'($urandom),
                     (i == 0) ? 1'b1 : rb(), rb(), (i == hcyc - 1));
            end
            m_pc = m_pc + 12'd1;
        end else if (is_two_exec(op)) begin
            step({nm, "_exec2"}, 3'b100, rst2, rb(), 16'($urandom), rb(), rb(), rb());
            if (rst2) begin
                m_pc = 12'h000;
                m_ir = 16'h0000;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        resume    = 1'b0;
        m_pc      = 12'h000;
        m_ir      = 16'h0000;
        @(posedge clk);
        #1;

        run_instr("ldi",   16'h0005, 0, 1'b0, 1'b1, 1, 1'b0);
        run_instr("add",   16'h2010, 0, 1'b0, 1'b1, 1, 1'b0);
        run_instr("jmp",   16'h43A0, 0, 1'b1, 1'b1, 1, 1'b0);
        run_instr("stall", 16'h8123, 3, 1'b0, 1'b1, 1, 1'b0);
        run_instr("jmp10", 16'h4010, 0, 1'b1, 1'b0, 1, 1'b0);
        run_instr("stp",   16'h7000, 0, 1'b0, 1'b0, 6, 1'b0);
        run_instr("jmpff", 16'h4FFF, 1, 1'b1, 1'b0, 1, 1'b0);
        run_instr("wrap",  16'h1000, 0, 1'b0, 1'b1, 1, 1'b0);
        run_instr("addrs", 16'h2000, 0, 1'b0, 1'b1, 1, 1'b1);
        run_instr("after", 16'hE555, 0, 1'b0, 1'b1, 1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            run_instr("rnd", 16'($urandom), $urandom_range(0, 2), rb(), rb(),
                      $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
        end

        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            failed = failed + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Control sequencer that sits directly upstream of the instruction decoder. It owns the program counter, the instruction register and the one-hot cycle state (fetch / exec1 / exec2). It fetches instruction words from memory under a ready handshake and presents opcode plus state to the decoder. It applies the decoder's pc_load/pc_inc back to the PC, and halts on STP.

Parameters:
ADDR_W, 12, width of PC and of the instruction operand field
DATA_W, 16, instruction word width; opcode = mem_rdata[DATA_W-1 -: 4], operand = mem_rdata[ADDR_W-1:0]

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
mem_rdata  in  DATA_W  instruction word from program memory
mem_ready  in  1  mem_rdata valid this cycle (sampled only in FETCH)
pc_load  in  1  from decoder: load PC with operand (sampled only in EXEC1)
pc_inc  in  1  from decoder: increment PC (sampled only in EXEC1)
resume  in  1  leave HALT and continue at PC+1
state  out  3  one-hot {exec2, exec1, fetch}; 000 in HALT
inst  out  4  latched opcode (IR[DATA_W-1 -: 4])
operand  out  ADDR_W  latched operand (IR[ADDR_W-1:0])
pc  out  ADDR_W  program counter, also the fetch address
fetch_req  out  1  high while in FETCH
halted  out  1  high while in HALT

Behaviour:
- One clock domain; reset is synchronous and active-high and overrides every other input on the same edge.
- Reset values: state=001 (FETCH), pc=0, IR=0 (inst=0000, operand=0), fetch_req=1, halted=0.
- States: FETCH=001, EXEC1=010, EXEC2=100, HALT=000. Any other encoding recovers to FETCH on the next edge. PC and IR are unchanged during recovery.
- FETCH:
  - fetch_req=1.
  - mem_ready=0: stay in FETCH; PC and IR hold.
  - mem_ready=1: IR<=mem_rdata and go to EXEC1. inst/operand show the new word from the next cycle.
- EXEC1 PC update:
  - pc_load=1: pc<=operand. pc_load has priority if both are high.
  - else pc_inc=1: pc<=pc+1, modulo 2^ADDR_W (0xFFF wraps to 0x000).
  - else: pc holds.
- EXEC1 next state:
  - inst=0111 (STP): go to HALT.
  - inst in {1000 LDA, 0010 ADD, 0011 SUB, 1101 XCH}: go to EXEC2.
  - all other opcodes, including unused 1110/1111: go to FETCH.
- EXEC2: unconditionally go to FETCH. PC and IR hold.
- HALT:
  - halted=1, fetch_req=0, state=000.
  - pc_load/pc_inc are ignored; PC stays at the STP address.
  - resume=1: pc<=pc+1 and go to FETCH. resume is ignored in every other state.
- Inputs outside their sampling state (mem_ready outside FETCH; pc_load/pc_inc outside EXEC1) have no effect.
- All outputs are registered or decoded only from registered state; no combinational path from any input to any output.
- Instruction latency: 2 cycles for single-exec instructions, 3 cycles for LDA/ADD/SUB/XCH, each assuming mem_ready=1 in FETCH.

Test Plan:
1. LDI with zero-wait fetch:
   - Stimulus: reset, then mem_ready=1 with word 0x0005; bench decoder model drives pc_inc=1 in EXEC1.
   - Required: state 001->010->001; inst=0, operand=0x005; pc 0x000->0x001 after EXEC1.
2. ADD two-exec instruction:
   - Stimulus: word 0x2010 at pc=0x001.
   - Required: state 001->010->100->001; pc=0x002 after EXEC1 and unchanged through EXEC2.
3. JMP load:
   - Stimulus: word 0x43A0 with pc_load=1 and pc_inc=1 both high in EXEC1.
   - Required: pc=0x3A0 (load wins); next FETCH presents pc=0x3A0.
4. Fetch stall:
   - Stimulus: mem_ready low for 3 cycles, then high with 0x8123.
   - Required: state holds 001, fetch_req=1, pc and previous IR stable for 3 cycles; then inst=8, operand=0x123, followed by EXEC1 then EXEC2.
5. STP and resume:
   - Stimulus: word 0x7000 at pc=0x010 with pc_inc=0; after 5 cycles pulse resume.
   - Required: state=000, halted=1, pc=0x010 held; stray pc_load ignored during HALT; after resume pc=0x011 and state=001.
6. Wrap and reset mid-operation:
   - Stimulus: pc=0xFFF with pc_inc in EXEC1; then assert reset during a later EXEC2.
   - Required: pc wraps to 0x000; on the cycle after reset, state=001, pc=0x000, inst=0, halted=0.
